fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Single-clock write-port arbiter that shares the asynchronous FIFO's write interface (`winc`/`wdata`/`wfull`) among `NUM_REQ` producers in the write clock domain. Fair round-robin ownership is held per grant, with beats forwarded under a valid/ready handshake that respects `wfull`. Sits directly in front of the FIFO write controller and memory write port.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum beats per grant when bursting is compiled in (1..16).
- `w_clk`  in  1  write-domain clock; all logic on rising edge.
- `w_rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed beats, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot (or zero) beat accepted this cycle.
- `wfull`  in  1  FIFO full flag from write controller.
- `winc`  out  1  FIFO write strobe.
- `wdata`  out  DATA_WIDTH  FIFO write data.
- `grant_valid`  out  1  a requester currently owns the port.
- `grant_id`  out  clog2(NUM_REQ)  current owner index.

## Operation
- States: IDLE, GRANT. Registers: `state`, `grant_id`, `last_id` (round-robin pointer), `beat_cnt`.
- Arbitration function: first i with `req_valid[i]`=1 scanning `last_id+1`, `last_id+2`, … modulo NUM_REQ.
- IDLE: if any `req_valid`, next state GRANT, `grant_id`/`last_id` <= winner, `beat_cnt` <= 0. No transfer in IDLE.
- GRANT, transfer condition `xfer = req_valid[grant_id] & ~wfull`.
  - `winc = xfer`; `req_ready[grant_id] = xfer`, other bits 0; `wdata = req_data` slice of `grant_id` (don't-care when `winc`=0).
  - On `xfer`: `beat_cnt` increments.
  - Release when owner `req_valid`=0 (no transfer that cycle), or `xfer` with `beat_cnt` = limit-1.
  - On release: rearbitrate in the same cycle (pointer = current `grant_id`); winner becomes owner next cycle with `beat_cnt` <= 0; if no requester valid, go IDLE.
  - `wfull`=1 stalls: no transfer, no count, no release unless owner drops valid.
- `grant_valid` = (state == GRANT).
- Requester must hold `req_valid` and `req_data` stable until `req_ready`; arbiter never drops an accepted beat.
- `winc` is never 1 while `wfull` is 1.

## Timing
- Reset values: state IDLE, `last_id` = NUM_REQ-1 (requester 0 wins first), `grant_id` 0, `beat_cnt` 0; `winc`, `req_ready`, `grant_valid` all 0. During the reset cycle `winc` and `req_ready` are forced 0.
- Reset mid-burst: next edge returns to IDLE; no beat transfers in the reset cycle.
- IDLE → first `winc`: 1 cycle after `req_valid` seen (granted at edge, beat on following cycle if `~wfull`).
- GRANT→GRANT handover: 0 idle cycles; continuous one beat per cycle while `~wfull` and any requester valid.
- `wfull` deasserting: transfer in the same cycle `wfull` is 0 (combinational path `wfull` → `winc`/`req_ready`).
- Pointer wrap: `grant_id` NUM_REQ-1 → search starts at 0.

## Configuration
- `WR_ARB_BURST_EN` defined: grant limit = MAX_BURST beats; owner keeps port for up to MAX_BURST consecutive transfers.
- Not defined: limit = 1; release after every beat (strict per-beat round robin); `beat_cnt` logic removed.

## Test plan
- Reset then single requester 2 valid with data 0xA5, `wfull`=0 -> `grant_valid` 1 next cycle, `grant_id`=2, `winc`=1 with `wdata`=0xA5, `req_ready`=4'b0100 same cycle.
- All 4 requesters valid continuously, macro off -> `grant_id` sequence 0,1,2,3,0,… one beat per cycle, no gaps.
- Macro on, MAX_BURST=4, requesters 0 and 1 always valid -> 4 beats from 0, then 4 beats from 1, then back to 0.
- `wfull`=1 for 3 cycles mid-grant -> `winc`=0, `req_ready`=0, `grant_id` unchanged; beats resume on the cycle `wfull` falls, none lost or duplicated (check data ordering per requester).
- Owner drops `req_valid` mid-burst while requester 3 valid -> handover to 3 next cycle, no `winc` on the drop cycle.
- Assert `w_rst` for 1 cycle during a burst -> `winc`=0 that cycle, state IDLE, next grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the async FIFO write port shared by NUM_REQ producers.
// Optional macro WR_ARB_BURST_EN lets an owner keep the port for up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          w_clk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [ID_W-1:0] ptr_s, win_id_s;
    logic            win_found_s;
    logic            owner_valid_s;
    logic            xfer_s;
    logic            last_beat_s;
    logic            release_s;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_param_check
        $error("fifo_wr_arbiter: parameter out of range");
    end

    // First valid requester after ptr, wrapping; {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] pick;
        int            idx;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[ID_W'(idx)]) begin
                pick = {1'b1, ID_W'(idx)};
            end
        end
        return pick;
    endfunction

`ifdef WR_ARB_BURST_EN
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    assign last_beat_s = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    // Beat counter: cleared on every release, otherwise counts transfers.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == GRANT) begin
            if (release_s) begin
                beat_cnt_d = '0;
            end else if (xfer_s) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
        end else begin
            beat_cnt_d = '0;
        end
    end

    // Beat counter register.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign last_beat_s = 1'b1;
`endif

    // Search starts after the current owner when granted, after the last owner when idle.
    assign ptr_s = (state_q == GRANT) ? grant_id_q : last_id_q;
    assign {win_found_s, win_id_s} = rr_pick(req_valid, ptr_s);

    // Write-port datapath; wfull reaches winc/req_ready combinationally.
    always_comb begin
        owner_valid_s = req_valid[grant_id_q];
        xfer_s        = ~w_rst & (state_q == GRANT) & owner_valid_s & ~wfull;
        release_s     = (state_q == GRANT) & (~owner_valid_s | (xfer_s & last_beat_s));
        req_ready     = '0;
        req_ready[grant_id_q] = xfer_s;
        winc          = xfer_s;
        wdata         = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    end

    // Ownership FSM next state.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d    = GRANT;
                    grant_id_d = win_id_s;
                    last_id_d  = win_id_s;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    if (win_found_s) begin
                        state_d    = GRANT;
                        grant_id_d = win_id_s;
                        last_id_d  = win_id_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ownership FSM registers; last_id resets so requester 0 wins first.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_id    = grant_id_q;

endmodule
